// File: rtl/fft_output_serializer.sv
// FFT result serializer: buffers sample pairs from the FFT I/O block in a
// small FIFO and emits one complex sample per cycle with frame markers.
//   clk, reset (async, active-high), en gates input acceptance only.
//   i_samp1/i_samp2/i_valid : pair stream in; o_receiver_ready back to source.
//   o_sample/o_valid/i_ready : serial valid/ready stream out.
//   o_last, o_frame_done, o_busy, o_overflow : frame and status flags.
module fft_output_serializer #(
  parameter int N            = 32,
  parameter int word_size    = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int READY_MARGIN = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [word_size*2-1:0] i_samp1,
  input  logic [word_size*2-1:0] i_samp2,
  input  logic                   i_valid,
  output logic                   o_receiver_ready,
  output logic [word_size*2-1:0] o_sample,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_last,
  output logic                   o_frame_done,
  output logic                   o_busy,
  output logic                   o_overflow
);

  localparam int SW  = word_size * 2;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int SCW = $clog2(N);

  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  RDY_LIM = CW'(FIFO_DEPTH - READY_MARGIN);
  localparam logic [SCW-1:0] LAST_C  = SCW'(N - 1);

  // pair storage, samp1 in the upper half; deliberately not reset
  logic [2*SW-1:0] mem_q [FIFO_DEPTH];

  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           half_q, half_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;

  logic            push_req;
  logic            full;
  logic            xfer;
  logic            pop;
  logic            push;
  logic [2*SW-1:0] head;

  always_comb begin
    push_req = i_valid & en;
    full     = (count_q == DEPTH_C);
    o_valid  = (count_q != '0);
    xfer     = o_valid & i_ready;
    pop      = xfer & half_q;
    // a pop in the same cycle frees the slot a full-FIFO push needs
    push     = push_req & (~full | pop);
    head     = mem_q[rd_ptr_q];

    o_sample = '0;
    if (o_valid) begin
      o_sample = half_q ? head[SW-1:0] : head[2*SW-1:SW];
    end

    o_last       = o_valid & (scnt_q == LAST_C);
    o_busy       = o_valid | (scnt_q != '0);
    o_overflow   = ovf_q;
    o_frame_done = done_q;
    // reset term keeps the output quiet while reset is held
    o_receiver_ready = en & ~reset & (count_q <= RDY_LIM);
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    half_d   = half_q;
    scnt_d   = scnt_q;
    ovf_d    = ovf_q;
    done_d   = xfer & o_last;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (push_req & ~push) begin
      ovf_d = 1'b1;
    end

    if (xfer) begin
      half_d = ~half_q;
      scnt_d = (scnt_q == LAST_C) ? '0 : scnt_q + SCW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      half_q   <= 1'b0;
      scnt_q   <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      half_q   <= half_d;
      scnt_q   <= scnt_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_samp1, i_samp2};
    end
  end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Testbench for fft_output_serializer: randomized stimulus checked
// against a queue-of-samples reference model.
module tb_fft_output_serializer;

  localparam int N      = 32;
  localparam int DEPTH  = 4;
  localparam int MARGIN = 2;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] i_samp1;
  logic [31:0] i_samp2;
  logic        i_valid;
  logic        o_receiver_ready;
  logic [31:0] o_sample;
  logic        o_valid;
  logic        i_ready;
  logic        o_last;
  logic        o_frame_done;
  logic        o_busy;
  logic        o_overflow;

  fft_output_serializer #(
    .N(N), .word_size(16),
    .FIFO_DEPTH(DEPTH), .READY_MARGIN(MARGIN)
  ) dut (
    .clk(clk),
    .reset(rst),
    .en(en),
    .i_samp1(i_samp1),
    .i_samp2(i_samp2),
    .i_valid(i_valid),
    .o_receiver_ready(o_receiver_ready),
    .o_sample(o_sample),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_last(o_last),
    .o_frame_done(o_frame_done),
    .o_busy(o_busy),
    .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // model: every buffered sample in output order
  logic [31:0] mq[$];
  int          tcnt;
  bit          m_ovf;
  bit          m_done;

  function automatic int m_pairs();
    return (mq.size() + 1) / 2;
  endfunction

  function automatic bit m_ready();
    return en && !rst && (m_pairs() <= DEPTH - MARGIN);
  endfunction

  function automatic logic [37:0] exp_vec();
    logic        v;
    logic [31:0] s;
    v = (mq.size() != 0);
    s = v ? mq[0] : 32'h0;
    return {m_ready(), v, v && (tcnt == N - 1), m_done,
            v || (tcnt != 0), m_ovf, s};
  endfunction

  function automatic logic [37:0] obs_vec();
    return {o_receiver_ready, o_valid, o_last, o_frame_done,
            o_busy, o_overflow, o_sample};
  endfunction

  function automatic void model_clear();
    mq.delete();
    tcnt   = 0;
    m_ovf  = 0;
    m_done = 0;
  endfunction

  function automatic void model_step();
    bit v, xfer, pop, full;
    v      = (mq.size() != 0);
    xfer   = v && (i_ready === 1'b1);
    pop    = xfer && (mq.size() % 2 == 1);
    full   = (m_pairs() == DEPTH);
    m_done = xfer && (tcnt == N - 1);
    if (xfer) begin
      void'(mq.pop_front());
      tcnt = (tcnt + 1) % N;
    end
    if (i_valid === 1'b1 && en === 1'b1) begin
      if (!full || pop) begin
        mq.push_back(i_samp1);
        mq.push_back(i_samp2);
      end else begin
        m_ovf = 1;
      end
    end
  endfunction

  function automatic logic [31:0] rnd();
    return $urandom & 32'h7fff_ffff;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    en      = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    en      = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_samp1 = '0;
    i_samp2 = '0;
    model_clear();
    @(negedge clk);
    #1;
    vectors++;
    if (obs_vec() !== 38'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", obs_vec());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_frame();
    int p = 0;
    int got = 0;
    do_reset();
    en      = 1'b1;
    i_ready = 1'b1;
    for (int c = 0; c < 200 && got < 32; c++) begin
      i_valid = (p < 16) && m_ready();
      i_samp1 = 32'(2 * p);
      i_samp2 = 32'(2 * p + 1);
      #1;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL frame_cycle c=%0d got=%h exp=%h",
                 c, obs_vec(), exp_vec());
      end
      if (o_valid && i_ready) begin
        vectors++;
        if (o_sample !== 32'(got) || o_last !== (got == 31)) begin
          errors++;
          $display("FAIL frame_order idx=%0d got=%0d last=%b",
                   got, o_sample, o_last);
        end
        got++;
      end
      if (i_valid) p++;
      tick();
    end
    i_valid = 1'b0;
    #1;
    vectors++;
    if (got !== 32) begin
      errors++;
      $display("FAIL frame_count got=%0d exp=32", got);
    end
    vectors++;
    if ({o_frame_done, o_overflow, o_busy} !== 3'b100) begin
      errors++;
      $display("FAIL frame_end done/ovf/busy got=%b exp=100",
               {o_frame_done, o_overflow, o_busy});
    end
    tick();
    #1;
    vectors++;
    if (o_frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_pulse got=%b exp=0", o_frame_done);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] first;
    i_ready = 1'b0;
    en      = 1'b1;
    first   = '0;
    for (int c = 0; c < 4; c++) begin
      i_valid = 1'b1;
      i_samp1 = rnd();
      i_samp2 = rnd();
      if (c == 0) first = i_samp1;
      #1;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL bp_cycle c=%0d got=%h exp=%h",
                 c, obs_vec(), exp_vec());
      end
      if (c == 3) begin
        vectors++;
        if (o_receiver_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready_at_3 got=%b exp=0", o_receiver_ready);
        end
      end
      if (c > 0) begin
        vectors++;
        if (o_sample !== first) begin
          errors++;
          $display("FAIL bp_hold got=%h exp=%h", o_sample, first);
        end
      end
      tick();
    end
    i_valid = 1'b0;
    #1;
    vectors++;
    if ({o_overflow, o_receiver_ready, o_sample} !== {2'b00, first}) begin
      errors++;
      $display("FAIL bp_full ovf=%b rdy=%b samp=%h exp 0 0 %h",
               o_overflow, o_receiver_ready, o_sample, first);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d1, d2;
    int got = 0;
    d1 = 32'hffff_ff00;
    d2 = 32'hffff_ff01;
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_samp1 = d1;
    i_samp2 = d2;
    tick();
    i_valid = 1'b0;
    #1;
    vectors++;
    if (o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got=%b exp=1", o_overflow);
    end
    i_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      vectors++;
      if (obs_vec() !== exp_vec() || o_overflow !== 1'b1) begin
        errors++;
        $display("FAIL ovf_drain c=%0d got=%h exp=%h",
                 c, obs_vec(), exp_vec());
      end
      if (o_valid) begin
        vectors++;
        if (o_sample === d1 || o_sample === d2) begin
          errors++;
          $display("FAIL ovf_dropped_seen got=%h exp=not dropped", o_sample);
        end
        got++;
      end
      tick();
    end
    vectors++;
    if (got !== 8) begin
      errors++;
      $display("FAIL ovf_drain_count got=%0d exp=8", got);
    end
  endtask

  task automatic test_reset_midframe();
    int p = 0;
    int got = 0;
    int c = 0;
    en      = 1'b1;
    i_ready = 1'b1;
    while (!(tcnt == 10 && mq.size() != 0) && c < 60) begin
      i_valid = m_ready();
      i_samp1 = rnd();
      i_samp2 = rnd();
      #1;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mid_pre c=%0d got=%h exp=%h",
                 c, obs_vec(), exp_vec());
      end
      tick();
      c++;
    end
    vectors++;
    if (tcnt != 10 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reach tcnt=%0d busy=%b exp=10 1", tcnt, o_busy);
    end
    i_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    model_clear();
    vectors++;
    if ({o_valid, o_busy, o_last, o_overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_async v/b/l/o got=%b exp=0000",
               {o_valid, o_busy, o_last, o_overflow});
    end
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL mid_async_all got=%h exp=%h", obs_vec(), exp_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 300 && got < 32; k++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      i_valid = (p < 16) && m_ready();
      i_samp1 = rnd();
      i_samp2 = rnd();
      #1;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mid_new k=%0d got=%h exp=%h",
                 k, obs_vec(), exp_vec());
      end
      if (o_valid && i_ready) begin
        vectors++;
        if (o_last !== (got == 31)) begin
          errors++;
          $display("FAIL mid_last idx=%0d got=%b", got, o_last);
        end
        got++;
      end
      if (i_valid) p++;
      tick();
    end
    i_valid = 1'b0;
    vectors++;
    if (got !== 32) begin
      errors++;
      $display("FAIL mid_new_count got=%0d exp=32", got);
    end
  endtask

  task automatic test_full_pushpop();
    int got = 0;
    do_reset();
    en      = 1'b1;
    i_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      i_valid = (c != 4);
      i_ready = (c >= 4);
      i_samp1 = rnd();
      i_samp2 = rnd();
      #1;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pp_cycle c=%0d got=%h exp=%h",
                 c, obs_vec(), exp_vec());
      end
      tick();
    end
    i_valid = 1'b0;
    #1;
    vectors++;
    if ({o_overflow, o_receiver_ready, o_valid} !== 3'b001) begin
      errors++;
      $display("FAIL pp_full ovf/rdy/v got=%b exp=001",
               {o_overflow, o_receiver_ready, o_valid});
    end
    for (int c = 0; c < 12; c++) begin
      #1;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pp_drain c=%0d got=%h exp=%h",
                 c, obs_vec(), exp_vec());
      end
      if (o_valid) got++;
      tick();
    end
    vectors++;
    if (got !== 8) begin
      errors++;
      $display("FAIL pp_drain_count got=%0d exp=8", got);
    end
  endtask

  task automatic test_en_off();
    int got = 0;
    en      = 1'b1;
    i_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      i_valid = 1'b1;
      i_samp1 = rnd();
      i_samp2 = rnd();
      tick();
    end
    en      = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      i_valid = c[0];
      i_samp1 = rnd();
      i_samp2 = rnd();
      #1;
      vectors++;
      if (obs_vec() !== exp_vec() || o_receiver_ready !== 1'b0) begin
        errors++;
        $display("FAIL en_off c=%0d got=%h exp=%h",
                 c, obs_vec(), exp_vec());
      end
      if (o_valid) got++;
      tick();
    end
    i_valid = 1'b0;
    #1;
    vectors++;
    if (got !== 4 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_off_drain got=%0d v=%b exp=4 0", got, o_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      en      = ($urandom_range(0, 7) != 0);
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 6);
      i_samp1 = rnd();
      i_samp2 = rnd();
      #1;
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b c=%0d got=%h exp=%h",
                 c, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_overflow();
    test_reset_midframe();
    test_full_pushpop();
    test_en_off();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
